// File: rtl/sub4_serial.sv
// -----------------------------------------------------------------------------
// sub4_serial -- bit-serial subtractor with a start/done handshake.
//
// Computes diff = (a - b - borrowIn) mod 2^WIDTH one bit per clock, LSB
// first, over WIDTH clocks. A single full-subtractor cell is reused for every
// bit position. Results are registered on the completing edge and held until
// the next operation completes (or reset).
//
// Optional feature macro: SUB4_SERIAL_OVERFLOW_EN
//   defined   : overflow_o is a registered signed-overflow flag for
//               a - b - borrowIn (two's complement, WIDTH bits).
//   undefined : overflow_o is tied to 0 and no flop is built for it.
//
// Parameters:
//   WIDTH         operand/result width in bits (2..16), default 4
//
// Ports:
//   clk_i         system clock, rising-edge active
//   reset_i       asynchronous, active-high reset
//   start_i       request pulse, honoured only in IDLE or DONE
//   a_i           minuend, sampled on the accepting edge
//   b_i           subtrahend, sampled on the accepting edge
//   borrow_in_i   incoming borrow, sampled on the accepting edge
//   diff_o        registered result (a - b - borrowIn) mod 2^WIDTH
//   borrow_out_o  registered final borrow (unsigned underflow)
//   busy_o        high while bit-steps are in progress
//   done_o        one-cycle completion pulse
//   overflow_o    signed overflow flag (0 unless SUB4_SERIAL_OVERFLOW_EN)
// -----------------------------------------------------------------------------
module sub4_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_in_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;

    // The minuend register doubles as the working register: each step it
    // shifts right, consuming its LSB, while the new difference bit enters
    // at the MSB. After WIDTH steps it holds the complete result.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             brw_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;
    logic             busy_q;
    logic             done_q;

    // One full-subtractor step on the current LSBs.
    logic             d_bit_d;
    logic             brw_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             last_step_d;

    assign d_bit_d     = a_q[0] ^ b_q[0] ^ brw_q;
    assign brw_d       = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    assign a_d         = {d_bit_d, a_q[WIDTH-1:1]};
    assign b_d         = {1'b0, b_q[WIDTH-1:1]};
    assign last_step_d = (cnt_q == LAST_STEP);

`ifdef SUB4_SERIAL_OVERFLOW_EN
    // On the final step the original operand MSBs have reached bit 0 of the
    // shift registers, and d_bit_d is the result MSB, so the overflow test
    // needs no extra storage for the operand sign bits.
    logic ovf_q;
    logic ovf_d;
    assign ovf_d = (a_q[0] != b_q[0]) && (d_bit_d != a_q[0]);
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            brw_q        <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SUB4_SERIAL_OVERFLOW_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                // IDLE and DONE are both ready states; DONE additionally
                // allows a back-to-back accept in its single cycle.
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        brw_q   <= borrow_in_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                // start_i is deliberately not looked at here.
                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    brw_q <= brw_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (last_step_d) begin
                        diff_q       <= a_d;
                        borrow_out_q <= brw_d;
`ifdef SUB4_SERIAL_OVERFLOW_EN
                        ovf_q        <= ovf_d;
`endif
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign diff_o       = diff_q;
    assign borrow_out_o = borrow_out_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

`ifdef SUB4_SERIAL_OVERFLOW_EN
    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: doc/sub4_serial.md
Name: sub4_serial

Overview:
- Bit-serial subtractor: the inverse-direction companion to the team's combinational 4-bit adder.
- Computes diff = a - b - borrowIn, LSB first, one bit per clock, over WIDTH clocks.
- Uses a start/done handshake so a single 1-bit datapath serves an area-constrained arithmetic path.
- Results are registered and held until the next operation completes.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when the block is ready (IDLE or DONE).
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- borrowIn  input  1  incoming borrow; sampled on the accepting edge.
- diff  output  WIDTH  registered result, (a - b - borrowIn) mod 2^WIDTH.
- borrowOut  output  1  registered final borrow; 1 when a < b + borrowIn (unsigned).
- busy  output  1  high while bit-steps are in progress.
- done  output  1  one-cycle completion pulse.
- overflow  output  1  signed overflow flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high; one clock, clk):
  - State goes to IDLE; diff=0, borrowOut=0, busy=0, done=0, overflow=0.
  - Internal shift registers and the bit counter clear.
- States:
  - IDLE: ready, busy=0, done=0. If start=1 on an edge, latch a, b, borrowIn into shift registers aReg, bReg and the borrow flop. Clear the counter. Go to RUN.
  - RUN: busy=1. Each edge performs one bit-step:
    - dBit = aReg[0] ^ bReg[0] ^ brw.
    - brw' = (~aReg[0] & bReg[0]) | (~(aReg[0] ^ bReg[0]) & brw).
    - dBit shifts into the MSB of the working register; aReg and bReg shift right.
    - The counter increments.
    - On the step where counter == WIDTH-1, the final working value and brw' are loaded into diff/borrowOut (and overflow), and the state goes to DONE.
  - DONE: busy=0, done=1 for exactly this cycle.
    - If start=1 on the next edge, the new operands are accepted (back-to-back) and the state goes to RUN.
    - Otherwise the state goes to IDLE.
- Latency: start accepted on edge k; busy is high during cycles k..k+WIDTH-1 (after edges k..k+WIDTH-1). Results update and done rises after edge k+WIDTH. With WIDTH=4, done is high in the 5th cycle after the start edge.
- Output holding:
  - diff, borrowOut and overflow change only on the completing edge (or reset). They never show partial values during RUN.
  - They hold their value through IDLE.
- Input sampling:
  - start while in RUN is ignored; the operation in flight is unaffected.
  - a, b and borrowIn may change freely after the accepting edge.
- Wrap-around: results are modulo 2^WIDTH. borrowOut is the sole unsigned-underflow indicator.
- Reset mid-RUN: the operation aborts immediately. Outputs go to reset values; no done pulse is produced.
- done and busy are never high simultaneously.

Optional Feature:
- Macro: SUB4_SERIAL_OVERFLOW_EN.
- Defined:
  - overflow is registered on the completing edge as (aMsb != bMsb) && (diffMsb != aMsb).
  - aMsb and bMsb are the operand MSBs latched at accept; diffMsb is the final result MSB.
  - borrowIn is included in the result, so the flag reflects a - b - borrowIn as signed.
- Undefined: the overflow port exists but is tied to 0; no extra flops.

Test Plan:
- WIDTH=4, a=13, b=1, borrowIn=0, start one cycle -> busy high 4 cycles; done pulses in the 5th cycle; diff=12, borrowOut=0.
- a=1, b=13, borrowIn=0 -> diff=4, borrowOut=1. a=0, b=0, borrowIn=1 -> diff=15, borrowOut=1.
- start held high continuously with a=5, b=3 then a=9, b=9:
  - Second operation accepted in the DONE cycle; done pulses twice, 5 cycles apart.
  - Results diff=2 then diff=0, borrowOut=0 both times.
- start re-pulsed mid-RUN with different operands -> ignored; result matches the originally latched operands; exactly one done.
- reset asserted asynchronously during 2nd bit-step -> all outputs 0 immediately, no done; a new start afterwards completes normally.
- With SUB4_SERIAL_OVERFLOW_EN:
  - a=8, b=1, borrowIn=0 -> diff=7, overflow=1.
  - a=7, b=15 -> diff=8, overflow=1.
  - a=3, b=2 -> overflow=0.
- Without SUB4_SERIAL_OVERFLOW_EN: overflow stays 0 for the same vectors.
